i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) with a 7-bit address and a small internal byte register file.
- Responds to the I2C master in the design's I2C block, or to an external master.
- Decodes START, repeated START, STOP, address, pointer, write data and read data on the bus.
- Mirrors each register write to the system side as a one-cycle strobe.
- Lets the system side read or preload the register file through a simple port.

Parameters:
- pDevAdrs, 7'h3C, 7-bit I2C address this target responds to.
- pRegNum, 16, number of byte registers (power of two, 2..256).
- pRegAdrsBit, 4, log2(pRegNum); width of the register pointer.

Ports:
- iSysClk  in  1  system clock; all logic on the rising edge.
- iSysRst  in  1  synchronous reset, active-high.
- iI2CScl  in  1  SCL from the bus (target never stretches SCL).
- iI2CSda  in  1  SDA from the bus.
- oI2CSdaOe  out  1  1 = pull SDA low; 0 = release. The top level builds the open-drain buffer.
- oWrStb  out  1  one-cycle pulse per data byte written by the master.
- oWrAdrs  out  pRegAdrsBit  register index of that write.
- oWrData  out  8  byte written.
- iHostAdrs  in  pRegAdrsBit  system-side register index.
- iHostWd  in  8  system-side write data.
- iHostWe  in  1  system-side write enable. On the same cycle as an I2C write to the same index, the I2C write wins.
- oHostRd  out  8  reg[iHostAdrs], registered; 1-cycle latency.
- oBusy  out  1  1 from START until STOP.

Behaviour:
- Input conditioning:
  - SCL and SDA each pass a 2-FF synchronizer, then a third register for edge detection.
  - Every event below is defined on the synchronized signals; this adds 3 cycles of latency.
  - Design assumption: iSysClk is at least 16x SCL.
- Bus events:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - START and STOP are detected in every state and override any state.
  - START enters ADDR and clears the bit counter; the pointer is kept.
  - STOP enters IDLE, clears oBusy and releases SDA.
- Bit timing:
  - Receive: sample SDA on each SCL rising edge, MSB first.
  - Transmit: change oI2CSdaOe only on SCL falling edges.
- State machine:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits.
    - On the 8th bit, if bits[7:1]==pDevAdrs, go to ADDR_ACK and save the R/W bit.
    - Otherwise go to IGNORE and never drive SDA.
  - ADDR_ACK:
    - On the next SCL falling edge, drive SDA low.
    - On the following falling edge, release SDA.
    - Then go to PTR if W, or to RDATA if R. For R, load the shifter with reg[ptr] and drive its MSB on that same falling edge.
  - PTR:
    - After 8 bits, ptr <= byte[pRegAdrsBit-1:0]; higher bits are ignored.
    - ACK the same way as ADDR_ACK, then go to WDATA.
  - WDATA:
    - After 8 bits, write reg[ptr] and pulse oWrStb once with oWrAdrs=ptr and oWrData=byte.
    - Then ptr <= ptr+1, wrapping modulo pRegNum.
    - ACK, then go back to WDATA.
  - RDATA:
    - Drive bits MSB first. A bit value of 1 means release SDA; 0 means drive SDA low.
    - After the 8th falling edge, release SDA and go to RACK.
  - RACK: sample SDA on the 9th rising edge.
    - ACK (0): ptr <= ptr+1 (wrap), load reg[ptr] and go to RDATA.
    - NACK (1): go to IGNORE with SDA released.
  - IGNORE: SDA released; waits for STOP or START.
- Reset values:
  - All outputs are 0.
  - The state machine is in IDLE and the pointer is 0.
  - All registers are 0, except oHostRd, which shows reg[iHostAdrs] one cycle after reset is released.
  - Reset during a transfer releases SDA on the next cycle, and the block stays IDLE until the next START.
- Edge cases:
  - A START during the ACK slot releases SDA on that same cycle.
  - The 9th-bit SDA drive is held until the SCL falling edge, so an ACK never glitches.

Test Plan:
- Write: START, 0x78, 0x05, 0xA5, 0x5A, STOP.
  - Target ACKs all 4 bytes.
  - oWrStb pulses twice: (5, A5), then (6, 5A).
  - reg[5]=A5 and reg[6]=5A, read back through iHostAdrs.
- Combined read: START, 0x78, 0x05, Sr, 0x79; master ACKs byte 1 and NACKs byte 2; STOP.
  - SDA carries A5 then 5A.
  - oI2CSdaOe is 0 after the NACK.
  - oBusy falls on STOP.
- Address mismatch: START, 0xA0, 0x00, STOP.
  - oI2CSdaOe stays 0 for the whole transfer and oWrStb never pulses.
- Pointer wrap: write ptr 0x0F with data 0x11, 0x22.
  - reg[15]=0x11 and reg[0]=0x22.
  - Pointer byte 0x13 addresses reg[3].
- Host preload: iHostWe writes reg[2]=0xC3, then I2C reads from ptr 2.
  - SDA carries C3.
  - When host and I2C write the same index in the same cycle, the I2C data is kept.
- Reset mid-read: assert iSysRst while the target drives a 0 bit.
  - oI2CSdaOe=0 on the next cycle.
  - A following full write transfer completes normally.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with a 7-bit address and a byte register file, plus a system-side host port.
// All bus activity is decoded from synchronized SCL/SDA; the target never stretches SCL.
module i2c_target_regs #(
  parameter logic [6:0] pDevAdrs    = 7'h3C,
  parameter int         pRegNum     = 16,
  parameter int         pRegAdrsBit = 4
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic                   iI2CScl,
  input  logic                   iI2CSda,
  output logic                   oI2CSdaOe,
  output logic                   oWrStb,
  output logic [pRegAdrsBit-1:0] oWrAdrs,
  output logic [7:0]             oWrData,
  input  logic [pRegAdrsBit-1:0] iHostAdrs,
  input  logic [7:0]             iHostWd,
  input  logic                   iHostWe,
  output logic [7:0]             oHostRd,
  output logic                   oBusy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WDATA,
    S_DATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               scl_sync_q, sda_sync_q;
  logic [3:0]               cnt_q, cnt_d;
  logic [7:0]               sh_q, sh_d;
  logic                     rw_q, rw_d;
  logic [pRegAdrsBit-1:0]   ptr_q, ptr_d;
  logic                     oe_q, oe_d;
  logic                     ackph_q, ackph_d;
  logic                     busy_q, busy_d;
  logic                     wr_en;
  logic                     wr_stb_q;
  logic [pRegAdrsBit-1:0]   wr_adrs_q;
  logic [7:0]               wr_data_q;
  logic [7:0]               host_rd_q;
  logic [7:0]               regs_q [pRegNum];

  logic                     scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0]               rx_byte, rd_byte;
  logic [pRegAdrsBit-1:0]   ptr_inc;

  // Stage 0/1: two-flop synchronizer; stage 2 holds the previous value for edge detection
  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_sync_q[2];
  assign scl_fall = ~scl_s & scl_sync_q[2];
  assign start    = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
  assign stop     = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;

  assign rx_byte  = {sh_q[6:0], sda_s};
  assign ptr_inc  = ptr_q + 1'b1;
  assign rd_byte  = regs_q[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rw_d    = rw_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    ackph_d = ackph_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      ackph_d = 1'b0;
      busy_d  = 1'b1;
    end else if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      ackph_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (rx_byte[7:1] == pDevAdrs) begin
              rw_d    = rx_byte[0];
              ackph_d = 1'b0;
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: if (scl_fall) begin
          if (!ackph_q) begin
            oe_d    = 1'b1;
            ackph_d = 1'b1;
          end else begin
            ackph_d = 1'b0;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            if (state_q == S_DATA_ACK) begin
              state_d = S_WDATA;
            end else if (rw_q) begin
              // First read bit goes out on the same falling edge that ends the ACK
              oe_d    = ~rd_byte[7];
              sh_d    = {rd_byte[6:0], 1'b0};
              cnt_d   = 4'd1;
              state_d = S_RDATA;
            end else begin
              state_d = S_PTR;
            end
          end
        end
        S_PTR, S_WDATA: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            ackph_d = 1'b0;
            state_d = S_DATA_ACK;
            if (state_q == S_PTR) begin
              ptr_d = rx_byte[pRegAdrsBit-1:0];
            end else begin
              wr_en = 1'b1;
              ptr_d = ptr_inc;
            end
          end
        end
        S_RDATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = S_RACK;
          end else begin
            oe_d  = ~sh_q[7];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_RACK: if (scl_rise) begin
          if (!sda_s) begin
            ptr_d   = ptr_inc;
            sh_d    = regs_q[ptr_inc];
            cnt_d   = 4'd0;
            state_d = S_RDATA;
          end else begin
            oe_d    = 1'b0;
            state_d = S_IGNORE;
          end
        end
        S_IGNORE: oe_d = 1'b0;
        default:  oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= '0;
      sda_sync_q <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      ackph_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_adrs_q  <= '0;
      wr_data_q  <= '0;
      host_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[1:0], iI2CScl};
      sda_sync_q <= {sda_sync_q[1:0], iI2CSda};
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      ackph_q    <= ackph_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_en;
      if (wr_en) begin
        wr_adrs_q <= ptr_q;
        wr_data_q <= rx_byte;
      end
      host_rd_q  <= regs_q[iHostAdrs];
    end
  end

  // The I2C write is issued last so it wins a same-index collision with the host
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      for (int i = 0; i < pRegNum; i++) regs_q[i] <= '0;
    end else begin
      if (iHostWe) regs_q[iHostAdrs] <= iHostWd;
      if (wr_en)   regs_q[ptr_q]     <= rx_byte;
    end
  end

  assign oI2CSdaOe = oe_q & ~(start | stop);
  assign oWrStb    = wr_stb_q;
  assign oWrAdrs   = wr_adrs_q;
  assign oWrData   = wr_data_q;
  assign oHostRd   = host_rd_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master drives the bus, results are
// compared against hand-computed values.
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       oe, wr_stb, busy, host_we;
  logic [3:0] wr_adrs, host_adrs;
  logic [7:0] wr_data, host_wd, host_rd;

  int n_chk = 0;
  int n_err = 0;
  int oe_cycles = 0;
  int stb_cnt = 0;
  logic [3:0] stb_a [0:63];
  logic [7:0] stb_d [0:63];
  logic       col_stb;

  assign sda_bus = sda_m & ~oe;
  always #5 clk = ~clk;

  i2c_target_regs #(.pDevAdrs(7'h3C), .pRegNum(16), .pRegAdrsBit(4)) dut (
    .iSysClk(clk), .iSysRst(rst), .iI2CScl(scl), .iI2CSda(sda_bus),
    .oI2CSdaOe(oe), .oWrStb(wr_stb), .oWrAdrs(wr_adrs), .oWrData(wr_data),
    .iHostAdrs(host_adrs), .iHostWd(host_wd), .iHostWe(host_we),
    .oHostRd(host_rd), .oBusy(busy)
  );

  always @(negedge clk) begin
    if (oe) oe_cycles++;
    if (wr_stb) begin
      stb_a[stb_cnt % 64] = wr_adrs;
      stb_d[stb_cnt % 64] = wr_data;
      stb_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; hq();
    scl = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq();
    scl = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  // col: pulse the host write enable on the exact cycle the I2C write lands
  task automatic write_bit(input logic b, input bit col);
    sda_m = b; hq();
    scl = 1'b1;
    if (col) begin
      @(negedge clk); @(negedge clk);
      host_we = 1'b1;
      @(negedge clk);
      col_stb = wr_stb;
      host_we = 1'b0;
      repeat (2*Q-3) @(negedge clk);
    end else begin
      repeat (2*Q) @(negedge clk);
    end
    scl = 1'b0; hq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; hq();
    scl = 1'b1; hq();
    b = sda_bus; hq();
    scl = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] d, input bit col_last, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], (i == 0) && col_last);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack, 1'b0);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_adrs = a; host_wd = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_adrs = a;
    @(negedge clk); @(negedge clk);
    d = host_rd;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack, b;
    logic [7:0] d;
    int         s0, o0;
    host_adrs = '0; host_wd = '0; host_we = 1'b0; col_stb = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_oe", oe, 0);
    check("rst_stb", wr_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_hostrd", host_rd, 0);
    check("rst_wradrs", wr_adrs, 0);
    check("rst_wrdata", wr_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain write: ptr 5, data A5 5A
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h78, 0, ack); check("w_addr_ack", ack, 1);
    write_byte(8'h05, 0, ack); check("w_ptr_ack", ack, 1);
    write_byte(8'hA5, 0, ack); check("w_d0_ack", ack, 1);
    write_byte(8'h5A, 0, ack); check("w_d1_ack", ack, 1);
    check("w_busy", busy, 1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("w_busy_off", busy, 0);
    check("w_stb_n", stb_cnt - s0, 2);
    check("w_stb0_a", stb_a[s0], 4'h5);
    check("w_stb0_d", stb_d[s0], 8'hA5);
    check("w_stb1_a", stb_a[s0+1], 4'h6);
    check("w_stb1_d", stb_d[s0+1], 8'h5A);
    host_read(4'd5, d); check("w_reg5", d, 8'hA5);
    host_read(4'd6, d); check("w_reg6", d, 8'h5A);

    // Combined read from ptr 5
    i2c_start();
    write_byte(8'h78, 0, ack); check("r_addr_ack", ack, 1);
    write_byte(8'h05, 0, ack); check("r_ptr_ack", ack, 1);
    i2c_rstart();
    write_byte(8'h79, 0, ack); check("r_raddr_ack", ack, 1);
    read_byte(1'b1, d); check("r_byte0", d, 8'hA5);
    read_byte(1'b0, d); check("r_byte1", d, 8'h5A);
    check("r_oe_nack", oe, 0);
    check("r_busy", busy, 1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("r_busy_off", busy, 0);

    // Address mismatch
    s0 = stb_cnt; o0 = oe_cycles;
    i2c_start();
    write_byte(8'hA0, 0, ack); check("m_addr_nack", ack, 0);
    write_byte(8'h00, 0, ack); check("m_d_nack", ack, 0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("m_oe_cycles", oe_cycles - o0, 0);
    check("m_stb_n", stb_cnt - s0, 0);

    // Pointer wrap and pointer high bits ignored
    i2c_start();
    write_byte(8'h78, 0, ack);
    write_byte(8'h0F, 0, ack);
    write_byte(8'h11, 0, ack);
    write_byte(8'h22, 0, ack); check("p_d1_ack", ack, 1);
    i2c_stop();
    host_read(4'd15, d); check("p_reg15", d, 8'h11);
    host_read(4'd0, d);  check("p_reg0", d, 8'h22);
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h78, 0, ack);
    write_byte(8'h13, 0, ack);
    write_byte(8'h3C, 0, ack);
    i2c_stop();
    check("p_stb_a", stb_a[s0], 4'h3);
    host_read(4'd3, d); check("p_reg3", d, 8'h3C);

    // Host preload then I2C read
    host_write(4'd2, 8'hC3);
    i2c_start();
    write_byte(8'h78, 0, ack);
    write_byte(8'h02, 0, ack);
    i2c_rstart();
    write_byte(8'h79, 0, ack);
    read_byte(1'b0, d); check("h_read", d, 8'hC3);
    i2c_stop();

    // Host and I2C write reg 8 in the same cycle
    host_adrs = 4'd8; host_wd = 8'h44;
    i2c_start();
    write_byte(8'h78, 0, ack);
    write_byte(8'h08, 0, ack);
    write_byte(8'h99, 1, ack);
    i2c_stop();
    check("c_aligned", col_stb, 1);
    host_read(4'd8, d); check("c_reg8", d, 8'h99);

    // Reset while the target drives a 0 bit (A5: bit7=1, bit6=0)
    i2c_start();
    write_byte(8'h78, 0, ack);
    write_byte(8'h05, 0, ack);
    i2c_rstart();
    write_byte(8'h79, 0, ack);
    read_bit(b); check("x_bit7", b, 1);
    check("x_oe_drive", oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("x_oe_rst", oe, 0);
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    check("x_busy", busy, 0);
    host_read(4'd5, d); check("x_reg5_clr", d, 8'h00);
    i2c_start();
    write_byte(8'h78, 0, ack); check("x_addr_ack", ack, 1);
    write_byte(8'h09, 0, ack); check("x_ptr_ack", ack, 1);
    write_byte(8'h66, 0, ack); check("x_d_ack", ack, 1);
    i2c_stop();
    host_read(4'd9, d); check("x_reg9", d, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
